// File: rtl/rgb_axis_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words) with SOF/EOL framing.
// Define RGB_PACKER_XRGB_EN to bypass packing and emit one zero-padded XRGB word per pixel.
module rgb_axis_packer #(
   parameter logic [7:0] PAD_BYTE  = 8'h00,
   parameter int         RGB_ORDER = 0
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   input  logic        valid,
   input  logic        sof,
   input  logic        eol,
   output logic        in_stream_ready,
   output logic [31:0] out_stream_tdata,
   output logic [3:0]  out_stream_tkeep,
   output logic        out_stream_tlast,
   output logic        out_stream_tuser,
   output logic        out_stream_tvalid,
   input  logic        out_stream_tready
);

   // state    | meaning
   // ST_PACK  | accepting pixels, phase = pixel index within the 4-pixel group
   // ST_FLUSH | eol hit mid-word; leftover hold bytes go out as a padded tlast word

   typedef enum logic {ST_PACK, ST_FLUSH} state_t;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_phase, w_phase_nxt;
   logic [23:0] r_hold, w_hold_nxt;
   logic        r_sof_pend, w_sof_pend_nxt;
   logic [31:0] r_tdata, w_tdata_nxt;
   logic [3:0]  r_tkeep, w_tkeep_nxt;
   logic        r_tlast, w_tlast_nxt;
   logic        r_tuser, w_tuser_nxt;
   logic        r_tvalid, w_tvalid_nxt;

   logic [7:0]  w_c0, w_c1, w_c2;
   logic        w_load_en;
   logic        w_accept;
   logic        w_ld;
   logic [31:0] w_ld_data;
   logic [3:0]  w_ld_keep;
   logic        w_ld_last;

   assign w_c0 = (RGB_ORDER == 0) ? r : b;
   assign w_c1 = g;
   assign w_c2 = (RGB_ORDER == 0) ? b : r;

   assign w_load_en       = !r_tvalid || out_stream_tready;
   assign in_stream_ready = (r_state == ST_PACK) && w_load_en;
   assign w_accept        = valid && in_stream_ready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= ST_PACK;
         r_phase    <= 2'd0;
         r_hold     <= 24'h0;
         r_sof_pend <= 1'b0;
         r_tdata    <= 32'h0;
         r_tkeep    <= 4'h0;
         r_tlast    <= 1'b0;
         r_tuser    <= 1'b0;
         r_tvalid   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_phase    <= w_phase_nxt;
         r_hold     <= w_hold_nxt;
         r_sof_pend <= w_sof_pend_nxt;
         r_tdata    <= w_tdata_nxt;
         r_tkeep    <= w_tkeep_nxt;
         r_tlast    <= w_tlast_nxt;
         r_tuser    <= w_tuser_nxt;
         r_tvalid   <= w_tvalid_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_phase_nxt    = r_phase;
      w_hold_nxt     = r_hold;
      w_sof_pend_nxt = r_sof_pend;
      w_tdata_nxt    = r_tdata;
      w_tkeep_nxt    = r_tkeep;
      w_tlast_nxt    = r_tlast;
      w_tuser_nxt    = r_tuser;
      w_tvalid_nxt   = r_tvalid && !out_stream_tready;
      w_ld           = 1'b0;
      w_ld_data      = 32'h0;
      w_ld_keep      = 4'h0;
      w_ld_last      = 1'b0;

`ifdef RGB_PACKER_XRGB_EN
      if (w_accept) begin
         w_ld      = 1'b1;
         w_ld_data = {8'h00, w_c2, w_c1, w_c0};
         w_ld_keep = 4'hF;
         w_ld_last = eol;
      end
`else
      unique case (r_state)
         ST_PACK: begin
            if (w_accept) begin
               case (r_phase)
                  2'd0: begin
                     w_hold_nxt = {w_c2, w_c1, w_c0};
                     if (eol) begin
                        w_ld      = 1'b1;
                        w_ld_data = {PAD_BYTE, w_c2, w_c1, w_c0};
                        w_ld_keep = 4'b0111;
                        w_ld_last = 1'b1;
                     end else begin
                        w_phase_nxt = 2'd1;
                     end
                  end
                  2'd1: begin
                     w_ld        = 1'b1;
                     w_ld_data   = {w_c0, r_hold};
                     w_ld_keep   = 4'hF;
                     w_hold_nxt  = {8'h00, w_c2, w_c1};
                     w_phase_nxt = 2'd2;
                     if (eol) w_state_nxt = ST_FLUSH;
                  end
                  2'd2: begin
                     w_ld        = 1'b1;
                     w_ld_data   = {w_c1, w_c0, r_hold[15:0]};
                     w_ld_keep   = 4'hF;
                     w_hold_nxt  = {16'h0000, w_c2};
                     w_phase_nxt = 2'd3;
                     if (eol) w_state_nxt = ST_FLUSH;
                  end
                  2'd3: begin
                     w_ld        = 1'b1;
                     w_ld_data   = {w_c2, w_c1, w_c0, r_hold[7:0]};
                     w_ld_keep   = 4'hF;
                     w_ld_last   = eol;
                     w_phase_nxt = 2'd0;
                  end
               endcase
            end
         end
         ST_FLUSH: begin
            // phase already advanced: 2 means two leftover bytes, 3 means one
            if (w_load_en) begin
               w_ld = 1'b1;
               if (r_phase == 2'd2) begin
                  w_ld_data = {PAD_BYTE, PAD_BYTE, r_hold[15:0]};
                  w_ld_keep = 4'b0011;
               end else begin
                  w_ld_data = {PAD_BYTE, PAD_BYTE, PAD_BYTE, r_hold[7:0]};
                  w_ld_keep = 4'b0001;
               end
               w_ld_last   = 1'b1;
               w_state_nxt = ST_PACK;
               w_phase_nxt = 2'd0;
            end
         end
         default: w_state_nxt = ST_PACK;
      endcase
`endif

      if (w_ld) begin
         w_tvalid_nxt   = 1'b1;
         w_tdata_nxt    = w_ld_data;
         w_tkeep_nxt    = w_ld_keep;
         w_tlast_nxt    = w_ld_last;
         w_tuser_nxt    = r_sof_pend || (w_accept && sof);
         w_sof_pend_nxt = 1'b0;
      end else if (w_accept && sof) begin
         w_sof_pend_nxt = 1'b1;
      end
   end

   assign out_stream_tdata  = r_tdata;
   assign out_stream_tkeep  = r_tkeep;
   assign out_stream_tlast  = r_tlast;
   assign out_stream_tuser  = r_tuser;
   assign out_stream_tvalid = r_tvalid;

endmodule

// File: tb/tb_rgb_axis_packer.sv
// Self-checking bench for rgb_axis_packer: random pixel lines compared against a byte-stream model.
// Honours RGB_PACKER_XRGB_EN so the same bench covers both builds.
module tb_rgb_axis_packer;
   localparam logic [7:0] PAD = 8'h5A;
   localparam int         ORD = 0;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [7:0]  r = 8'h0, g = 8'h0, b = 8'h0;
   logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
   logic        in_stream_ready;
   logic [31:0] out_stream_tdata;
   logic [3:0]  out_stream_tkeep;
   logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
   logic        out_stream_tready = 1'b0;

   rgb_axis_packer #(.PAD_BYTE(PAD), .RGB_ORDER(ORD)) dut (
      .aclk(aclk), .aresetn(aresetn), .r(r), .g(g), .b(b),
      .valid(valid), .sof(sof), .eol(eol), .in_stream_ready(in_stream_ready),
      .out_stream_tdata(out_stream_tdata), .out_stream_tkeep(out_stream_tkeep),
      .out_stream_tlast(out_stream_tlast), .out_stream_tuser(out_stream_tuser),
      .out_stream_tvalid(out_stream_tvalid), .out_stream_tready(out_stream_tready));

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [23:0] pix[$];
   logic [37:0] exp_q[$];   // {tuser, tlast, tkeep, tdata}
   logic [37:0] got_q[$];
   int stall_viol;
   int ready_low;

`ifdef RGB_PACKER_XRGB_EN
   localparam bit XRGB = 1'b1;
`else
   localparam bit XRGB = 1'b0;
`endif

   // Reference: serialise pixels to a byte stream, cut into 4-byte words, pad the tail.
   function automatic void build_expected();
      logic [7:0] bytes[$];
      int nw;
      exp_q.delete();
      foreach (pix[i]) begin
         logic [7:0] l0, l1, l2;
         l0 = (ORD == 0) ? pix[i][23:16] : pix[i][7:0];
         l1 = pix[i][15:8];
         l2 = (ORD == 0) ? pix[i][7:0] : pix[i][23:16];
         if (XRGB)
            exp_q.push_back({i == 0, i == pix.size() - 1, 4'hF, 8'h00, l2, l1, l0});
         else begin
            bytes.push_back(l0); bytes.push_back(l1); bytes.push_back(l2);
         end
      end
      if (!XRGB) begin
         nw = (bytes.size() + 3) / 4;
         for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            logic [3:0]  k;
            for (int j = 0; j < 4; j++) begin
               if (4 * w + j < bytes.size()) begin
                  d[8*j +: 8] = bytes[4 * w + j];
                  k[j] = 1'b1;
               end else begin
                  d[8*j +: 8] = PAD;
                  k[j] = 1'b0;
               end
            end
            exp_q.push_back({w == 0, w == nw - 1, k, d});
         end
      end
   endfunction

   // Drives pix[] as one line (sof on first, eol on last), collects output words, compares to model.
   task automatic run_line(input bit rnd_ready, input bit rnd_valid, input string name);
      int idx = 0;
      int cyc = 0;
      int limit;
      bit prev_stall = 1'b0;
      logic [37:0] prev_word = '0;
      build_expected();
      got_q.delete();
      stall_viol = 0;
      ready_low  = 0;
      limit = pix.size() * 6 + 100;
      while ((idx < pix.size() || got_q.size() < exp_q.size()) && cyc < limit) begin
         @(posedge aclk); #1;
         out_stream_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (idx < pix.size() && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
            valid = 1'b1;
            {r, g, b} = pix[idx];
            sof = (idx == 0);
            eol = (idx == pix.size() - 1);
         end else begin
            valid = 1'b0; sof = 1'b0; eol = 1'b0;
         end
         @(negedge aclk);
         if (prev_stall && (!out_stream_tvalid || {out_stream_tuser, out_stream_tlast,
             out_stream_tkeep, out_stream_tdata} != prev_word))
            stall_viol++;
         prev_stall = out_stream_tvalid && !out_stream_tready;
         prev_word  = {out_stream_tuser, out_stream_tlast, out_stream_tkeep, out_stream_tdata};
         if (!in_stream_ready) ready_low++;
         if (valid && in_stream_ready) idx++;
         if (out_stream_tvalid && out_stream_tready) got_q.push_back(prev_word);
         cyc++;
      end
      @(posedge aclk); #1;
      valid = 1'b0; sof = 1'b0; eol = 1'b0; out_stream_tready = 1'b1;
      n_checks++;
      if (cyc >= limit) begin
         n_fail++;
         $display("FAIL %s timeout: accepted %0d of %0d pixels, got %0d of %0d words",
                  name, idx, pix.size(), got_q.size(), exp_q.size());
      end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL %s word count: got %0d expected %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s word %0d: got user=%0b last=%0b keep=%h data=%h expected user=%0b last=%0b keep=%h data=%h",
                     name, i, got_q[i][37], got_q[i][36], got_q[i][35:32], got_q[i][31:0],
                     exp_q[i][37], exp_q[i][36], exp_q[i][35:32], exp_q[i][31:0]);
         end
      end
   endtask

   task automatic rand_line(input int n);
      pix.delete();
      for (int i = 0; i < n; i++) pix.push_back(24'($urandom()));
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      n_checks++;
      if (out_stream_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset tvalid: got %b expected 0", out_stream_tvalid); end
      n_checks++;
      if (out_stream_tdata !== 32'h0) begin n_fail++; $display("FAIL reset tdata: got %h expected 0", out_stream_tdata); end
      n_checks++;
      if (out_stream_tkeep !== 4'h0) begin n_fail++; $display("FAIL reset tkeep: got %h expected 0", out_stream_tkeep); end
      n_checks++;
      if ({out_stream_tlast, out_stream_tuser} !== 2'b00) begin
         n_fail++; $display("FAIL reset tlast/tuser: got %b%b expected 00", out_stream_tlast, out_stream_tuser);
      end
      n_checks++;
      if (in_stream_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b expected 1", in_stream_ready); end
      @(posedge aclk); #1;
      aresetn = 1'b1;
      out_stream_tready = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] exp_d[3];
      pix.delete();
      pix.push_back(24'h010203); pix.push_back(24'h040506);
      pix.push_back(24'h070809); pix.push_back(24'h0A0B0C);
      run_line(1'b0, 1'b0, "basic");
      exp_d[0] = 32'h04030201; exp_d[1] = 32'h08070605; exp_d[2] = 32'h0C0B0A09;
      if (!XRGB) begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i][35:0] !== {4'hF, exp_d[i]}) begin
               n_fail++;
               $display("FAIL basic literal word %0d: got %h expected keep=F data=%h",
                        i, (i < got_q.size()) ? got_q[i] : 38'h0, exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_line640();
      int tu = 0, tl = 0;
      rand_line(640);
      run_line(1'b0, 1'b0, "line640");
      n_checks++;
      if (got_q.size() !== (XRGB ? 640 : 480)) begin
         n_fail++; $display("FAIL line640 count: got %0d expected %0d", got_q.size(), XRGB ? 640 : 480);
      end
      foreach (got_q[i]) begin tu += got_q[i][37]; tl += got_q[i][36]; end
      n_checks++;
      if (tu !== 1 || tl !== 1 || got_q.size() == 0 || got_q[0][37] !== 1'b1 || got_q[got_q.size()-1][36] !== 1'b1) begin
         n_fail++; $display("FAIL line640 framing: tuser count %0d tlast count %0d expected 1 and 1 at ends", tu, tl);
      end
      n_checks++;
      if (ready_low !== 0) begin n_fail++; $display("FAIL line640 ready low cycles: got %0d expected 0", ready_low); end
   endtask

   task automatic test_eol_phases();
      int lens[4];
      lens[0] = 1; lens[1] = 5; lens[2] = 6; lens[3] = 7;
      foreach (lens[i]) begin
         rand_line(lens[i]);
         run_line(1'b0, 1'b0, $sformatf("eol_len%0d", lens[i]));
         n_checks++;
         if (ready_low !== ((!XRGB && (lens[i] == 6 || lens[i] == 7)) ? 1 : 0)) begin
            n_fail++; $display("FAIL eol_len%0d ready low cycles: got %0d", lens[i], ready_low);
         end
      end
      if (!XRGB) begin
         rand_line(6);
         run_line(1'b0, 1'b0, "eol_phase1");
         n_checks++;
         if (got_q.size() !== 5 || got_q[4][36:32] !== 5'b10011) begin
            n_fail++; $display("FAIL eol_phase1 tail: got %0d words, last last/keep=%b expected 5 words, 1/0011",
                               got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1][36:32] : 5'h0);
         end
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 3; k++) begin
         rand_line(12);
         run_line(1'b1, 1'b0, "backpressure");
         n_checks++;
         if (stall_viol !== 0) begin n_fail++; $display("FAIL backpressure stability: got %0d violations expected 0", stall_viol); end
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) begin
         rand_line($urandom_range(1, 20));
         run_line(1'b1, 1'b1, "back_to_back");
         n_checks++;
         if (stall_viol !== 0) begin n_fail++; $display("FAIL back_to_back stability: got %0d violations expected 0", stall_viol); end
      end
   endtask

   task automatic test_reset_mid_group();
      @(posedge aclk); #1;
      out_stream_tready = 1'b1;
      valid = 1'b1; sof = 1'b1; eol = 1'b0; {r, g, b} = 24'hDEAD01;
      @(posedge aclk); #1;
      sof = 1'b0; {r, g, b} = 24'hBEEF02;
      @(posedge aclk); #1;
      valid = 1'b0; out_stream_tready = 1'b0;
      @(negedge aclk);
      n_checks++;
      if (out_stream_tvalid !== 1'b1) begin n_fail++; $display("FAIL midreset setup tvalid: got %b expected 1", out_stream_tvalid); end
      #2 aresetn = 1'b0;
      #1;
      n_checks++;
      if (out_stream_tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset tvalid: got %b expected 0", out_stream_tvalid); end
      @(posedge aclk); #1;
      aresetn = 1'b1;
      rand_line(4);
      run_line(1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_xrgb();
      pix.delete();
      pix.push_back(24'hAABBCC);
      run_line(1'b0, 1'b0, "xrgb");
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== {1'b1, 1'b1, 4'hF, 32'h00CCBBAA}) begin
         n_fail++; $display("FAIL xrgb word: got %0d words first=%h expected one word 3f00ccbbaa",
                            got_q.size(), (got_q.size() > 0) ? got_q[0] : 38'h0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_line640();
      test_eol_phases();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_group();
      if (XRGB) test_xrgb();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
